// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode hex display driver with a frame-synchronous shadow copy.
// Optional PWM brightness control is compiled in when SEG7_DIM_EN is defined.
module seg7_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int DIM_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   val,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  blank_en,
`ifdef SEG7_DIM_EN
  input  logic [DIM_BITS-1:0]   bright,
`endif
  output logic                  busy,
  output logic                  frame,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     dig
);

  localparam int PCW = $clog2(PRESCALE);
  localparam int SW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PCW-1:0] PC_LAST   = PCW'(PRESCALE - 1);
  localparam logic [SW-1:0]  SLOT_LAST = SW'(DIGITS - 1);

  logic [PCW-1:0]      r_pc;
  logic [SW-1:0]       r_s;
  logic [4*DIGITS-1:0] r_st_val, r_sh_val;
  logic [DIGITS-1:0]   r_st_dp, r_sh_dp;
  logic                r_pending;
  logic [6:0]          r_seg;
  logic                r_dp_n;
  logic [DIGITS-1:0]   r_dig;

  logic       w_tick, w_boundary, w_gate, w_blank, w_lit, w_dp_sel, w_upper_nz;
  logic [3:0] w_nib;
  logic [6:0] w_glyph;

  assign w_tick     = (r_pc == PC_LAST);
  assign w_boundary = w_tick && (r_s == SLOT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
      r_s  <= '0;
    end else if (w_tick) begin
      r_pc <= '0;
      r_s  <= (r_s == SLOT_LAST) ? '0 : r_s + SW'(1);
    end else begin
      r_pc <= r_pc + PCW'(1);
    end
  end

  // A load landing on the boundary bypasses staging so it is never held a full extra frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st_val  <= '0;
      r_st_dp   <= '0;
      r_sh_val  <= '0;
      r_sh_dp   <= '0;
      r_pending <= 1'b0;
    end else begin
      if (load) begin
        r_st_val <= val;
        r_st_dp  <= dp;
      end
      if (w_boundary && load) begin
        r_sh_val  <= val;
        r_sh_dp   <= dp;
        r_pending <= 1'b0;
      end else if (w_boundary && r_pending) begin
        r_sh_val  <= r_st_val;
        r_sh_dp   <= r_st_dp;
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

`ifdef SEG7_DIM_EN
  logic [DIM_BITS-1:0] r_pw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pw <= '0;
    else        r_pw <= r_pw + DIM_BITS'(1);
  end

  assign w_gate = (r_pw <= bright);
`else
  assign w_gate = (DIM_BITS >= 1);
`endif

  // Leading-zero test covers the active slot and every more-significant nibble.
  always_comb begin
    w_nib      = '0;
    w_dp_sel   = 1'b0;
    w_upper_nz = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (SW'(i) == r_s) begin
        w_nib    = r_sh_val[4*i +: 4];
        w_dp_sel = r_sh_dp[i];
      end
      if ((SW'(i) >= r_s) && (r_sh_val[4*i +: 4] != 4'h0)) w_upper_nz = 1'b1;
    end
  end

  assign w_blank = (r_s != '0) && blank_en && !w_upper_nz && !w_dp_sel;
  assign w_lit   = !w_blank && (r_pc != '0) && w_gate;

  always_comb begin
    w_glyph = '1;
    case (w_nib)
      4'h0: w_glyph = 7'b0000001;
      4'h1: w_glyph = 7'b1001111;
      4'h2: w_glyph = 7'b0010010;
      4'h3: w_glyph = 7'b0000110;
      4'h4: w_glyph = 7'b1001100;
      4'h5: w_glyph = 7'b0100100;
      4'h6: w_glyph = 7'b0100000;
      4'h7: w_glyph = 7'b0001111;
      4'h8: w_glyph = 7'b0000000;
      4'h9: w_glyph = 7'b0000100;
      4'hA: w_glyph = 7'b0001000;
      4'hB: w_glyph = 7'b1100000;
      4'hC: w_glyph = 7'b0110001;
      4'hD: w_glyph = 7'b1000010;
      4'hE: w_glyph = 7'b0110000;
      4'hF: w_glyph = 7'b0111000;
      default: w_glyph = '1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg  <= '1;
      r_dp_n <= 1'b1;
      r_dig  <= '1;
    end else begin
      r_seg  <= w_blank ? '1 : w_glyph;
      r_dp_n <= w_blank | ~w_dp_sel;
      r_dig  <= '1;
      if (w_lit) r_dig[r_s] <= 1'b0;
    end
  end

  assign busy  = r_pending;
  assign frame = w_boundary;
  assign seg   = r_seg;
  assign dp_n  = r_dp_n;
  assign dig   = r_dig;

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Parametrised time-multiplexed hex display driver for common-anode 7-segment banks of any digit count. It holds a tear-free shadow copy of the displayed value, which is updated only at frame boundaries through a load handshake. It also provides per-digit decimal points, run-time leading-zero blanking and an optional PWM brightness control. It sits between a data-processing core (ROM readout, counters) and the board's segment and anode pins.

## Interface
- DIGITS, 4: number of digits, 1..8.
- PRESCALE, 50000: clk cycles per digit slot, ≥ 2.
- DIM_BITS, 4: brightness resolution in bits. Used only with SEG7_DIM_EN.

- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- val  in  4*DIGITS  hex value; nibble i drives digit i, with digit 0 the rightmost.
- dp  in  DIGITS  decimal point request per digit, active-high.
- load  in  1  one-cycle strobe; captures val and dp for display.
- blank_en  in  1  enables leading-zero blanking.
- bright  in  DIM_BITS  brightness level. Present only with SEG7_DIM_EN.
- busy  out  1  a captured load has not yet reached the display.
- frame  out  1  one-cycle pulse on the last cycle of each frame.
- seg  out  7  segments a..g on seg[6]..seg[0], active-low.
- dp_n  out  1  decimal point segment, active-low.
- dig  out  DIGITS  anode enables, active-low.

## Operation
**Reset values**
- Prescaler count `pc` = 0, slot index `s` = 0, staging = 0, shadow = 0, `pending` = 0.
- busy = 0, frame = 0, seg = 7'b1111111, dp_n = 1, dig = all ones.

**Counters**
- `pc` counts 0..PRESCALE-1. `tick` is asserted when `pc` = PRESCALE-1, and `pc` then wraps to 0.
- On `tick`, `s` advances by one and wraps from DIGITS-1 to 0.
- The boundary cycle is `tick` with `s` = DIGITS-1. frame = 1 on exactly that cycle.

**Load handshake**
- When load = 1: staging ← {val, dp} and `pending` ← 1.
- A load while `pending` = 1 overwrites staging; the latest load wins.
- On the boundary cycle with `pending` = 1: shadow ← staging and `pending` ← 0.
- If load = 1 on the boundary cycle itself: shadow ← {val, dp} directly and `pending` stays 0.
- busy reflects `pending`.

**Digit decode**
- Nibble 0..F maps to the standard hex glyph, active-low: 0 = 0000001, 8 = 0000000, A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000, F = 0111000.

**Blanking**
- Digit i > 0 is blank when all of the following hold:
  - blank_en = 1,
  - shadow nibbles i..DIGITS-1 are all zero,
  - shadow dp[i] = 0.
- Digit 0 is never blank.
- A blank digit keeps its anode off for the whole slot.

**Anode enable**
- dig[s] = 0 only when the digit is not blank, `pc` ≠ 0, and the PWM gate is open.
- All other anode bits are 1.
- `pc` = 0 is a one-cycle dead time at the start of each slot, used for anti-ghosting.

**Outputs**
- seg, dp_n and dig are registered.

## Timing
- Frame period is DIGITS × PRESCALE cycles.
- Outputs lag the internal state (`s`, `pc`, shadow) by 1 cycle.
- load → busy rises on the next cycle. busy stays high until the cycle after the boundary; worst case is one full frame.
- New shadow content first appears on seg/dig 1 cycle after the boundary, during slot 0. The anode stays off for that slot's dead cycle.
- Reset may be asserted at any time. All outputs take their reset values asynchronously and any pending load is discarded.
- DIGITS = 1: `s` stays 0 and every `tick` is a boundary.

## Configuration
- SEG7_DIM_EN defined:
  - The bright port and a free-running DIM_BITS-bit counter `pw` are compiled in.
  - The PWM gate is open when `pw` ≤ bright.
  - bright = all ones gives full on; bright = 0 gives a duty of 1/2^DIM_BITS.
  - `pw` resets to 0.
- SEG7_DIM_EN undefined:
  - No bright port and no `pw` counter.
  - The PWM gate is always open.

## Test plan
Scenarios use DIGITS = 4 and PRESCALE = 4.

- **Reset and idle scan:** release reset with no load. Required: dig cycles through 1110, 1101, 1011, 0111, each digit low 3 of every 4 cycles. seg = 0000001 throughout. frame pulses every 16 cycles.
- **Load applied at boundary:** load val = 16'h1A3F mid-frame. Required: busy rises the next cycle and falls after the boundary. The next frame shows F, 3, A, 1, i.e. seg = 0111000, 0000110, 0001000, 1001111.
- **Back-to-back loads:** load 16'h1111 and then 16'h2222 within one frame. Required: only 2222 is displayed. A load on the boundary cycle is applied immediately and busy never rises.
- **Blanking:** val = 16'h0050, dp = 4'b0100, blank_en = 1. Required:
  - Digit 3 is blank.
  - Digit 2 shows 0 with dp_n = 0.
  - Digits 1 and 0 show 5 and 0.
  - With blank_en = 0, all four digits are lit.
- **Brightness (SEG7_DIM_EN, DIM_BITS = 2):** bright = 1. Required: within the enabled cycles of each slot, dig[s] is low only when `pw` ∈ {0, 1}.
- **Reset mid-operation:** assert rst_n = 0 while busy = 1. Required: dig = 1111, seg = 1111111 and busy = 0 asynchronously. After release, the display shows 0 and the discarded load is not applied.
